wide_add_sequencer: RTL and testbench

//  Multi-cycle wide adder. Streams NWORDS 16-bit slices of two operands through one

---
 rtl/wide_add_sequencer.sv | 160 ++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-cycle wide adder. The two W-bit operands (W = 16*NWORDS) are captured
//   once, then streamed LSW first through a single 16-bit Sklansky prefix adder,
//   one slice per cycle, with the slice carry-out registered as the next
//   slice's carry-in. Valid/ready handshakes on both the operand and result side.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands and carry-in valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   a, b       in   W   operands
//   cin        in   1   carry into slice 0
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   sum        out  W   a+b+cin modulo 2^W
//   cout       out  1   carry out of bit W-1
//   ovf        out  1   two's complement overflow of the W-bit sum
//   busy       out  1   high in RUN or DONE

// Skalansky_Exact
//   16-bit combinational Sklansky parallel-prefix adder. Cin is treated as the
//   generate term of an extra prefix position 0, so every group carry comes out
//   of the same log-depth tree. Cout[k] is the carry out of bit k; only the top
//   two are exported (carry into and out of the MSB).
module Skalansky_Exact (
    input  logic [16:1]  A,
    input  logic [16:1]  B,
    input  logic         Cin,
    output logic [16:1]  Sum,
    output logic [16:15] Cout
);
    logic [16:0] g;
    logic [16:0] p;
    logic [16:1] hs;

    assign hs = A ^ B;

    // Level l combines each node whose bit l is set with the last node of the
    // lower half-block; that node has bit l clear, so it is never rewritten in
    // the same level and in-place update is safe.
    always_comb begin
        g = {A & B, Cin};
        p = {hs, 1'b0};
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 17; i++) begin
                if (((i >> l) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
                    p[i] = p[i] & p[((i >> l) << l) - 1];
                end
            end
        end
    end

    assign Sum  = hs ^ g[15:0];
    assign Cout = g[16:15];
endmodule

module wide_add_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NWORDS-1:0] a,
    input  logic [16*NWORDS-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NWORDS-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic [16:1]     core_sum;
    logic [16:15]    core_cout;

    Skalansky_Exact u_core (
        .A    (a_reg[{idx, 4'b0000} +: 16]),
        .B    (b_reg[{idx, 4'b0000} +: 16]),
        .Cin  (carry),
        .Sum  (core_sum),
        .Cout (core_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 4'b0000} +: 16] <= core_sum;
                    carry <= core_cout[16];
                    if (idx == IW'(NWORDS - 1)) begin
                        cout_reg  <= core_cout[16];
                        // Carry into the MSB differs from carry out of it.
                        ovf_reg   <= core_cout[15] ^ core_cout[16];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;
    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    wide_add_sequencer #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        int mode;
        mode = $urandom_range(0, 5);
        for (int i = 0; i < NWORDS; i++) begin
            case (mode)
                0:       r[i*16 +: 16] = 16'hFFFF;
                1:       r[i*16 +: 16] = 16'h0000;
                default: r[i*16 +: 16] = 16'($urandom);
            endcase
        end
        if (mode == 2) r[W-1] = ~r[W-1];
        return r;
    endfunction

    // One full transaction: idle gap, accept, wait for result, hold in DONE,
    // handshake. The reference is plain wide arithmetic plus the sign rule for
    // overflow.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_c, input int gap, input int hold,
                         input string name);
        logic [W:0]   full;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
        int           lat;
        full  = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c};
        esum  = full[W-1:0];
        ecout = full[W];
        eovf  = (op_a[W-1] == op_b[W-1]) && (esum[W-1] != op_a[W-1]);

        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (gap) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
        end
        a = op_a; b = op_b; cin = op_c; in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s run_flags: in_ready=%b busy=%b want 0/1", name, in_ready, busy);
            end
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a = rand_word(); b = rand_word(); cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NWORDS) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NWORDS);
        end
        checks++;
        if (sum !== esum || cout !== ecout || ovf !== eovf) begin
            errors++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, esum, ecout, eovf);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rand_word(); b = rand_word();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                sum !== esum || cout !== ecout || ovf !== eovf) begin
                errors++;
                $display("FAIL %s hold: out_valid=%b in_ready=%b sum=%h cout=%b want 1/0 sum=%h cout=%b",
                         name, out_valid, in_ready, sum, cout, esum, ecout);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            sum !== esum || cout !== ecout || ovf !== eovf) begin
            errors++;
            $display("FAIL %s after_handshake: out_valid=%b in_ready=%b busy=%b sum=%h want 0/1/0 sum=%h",
                     name, out_valid, in_ready, busy, sum, esum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 ||
            cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b busy=%b want 1/0/0/0/0/0",
                     in_ready, out_valid, sum, cout, ovf, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_add();
        do_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 0, 0, "small_add");
    endtask

    task automatic test_ripple();
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1, "ripple");
    endtask

    task automatic test_signed_ovf();
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, "signed_ovf");
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 0, "neg_ovf");
    endtask

    task automatic test_stall();
        do_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 2, 10, "stall");
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] full;
        in_valid = 1'b0;
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0001_0001_0001_0001; cin = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: in_ready=%b out_valid=%b sum=%h busy=%b want 1/0/0/0",
                     in_ready, out_valid, sum, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        full = {1'b0, a} + 65'd5;
        do_op(full[W-1:0], 64'd3, 1'b1, 1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 0, 0, "back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++)
            do_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), "random");
    endtask

    initial begin
        test_reset();
        test_small_add();
        test_ripple();
        test_signed_ovf();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
